pipeline_result_accumulator: RTL and testbench

- Downstream consumer of the 16-bit result stream from the unsigned arithmetic pipeline.
- Collects WIN consecutive valid results into one window and emits the window sum and window maximum through a single-entry valid/ready output register.
- Applies backpressure upstream only when a finished window cannot be delivered.

---
 rtl/pipeline_result_accumulator_if.sv | 23 ++
 rtl/pipeline_result_accumulator.sv | 68 ++++++
 tb/tb_pipeline_result_accumulator.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_result_accumulator_if.sv
// rtl/pipeline_result_accumulator_if.sv - input/output stream bundle for the result accumulator
interface pipeline_result_accumulator_if #(
    parameter int DW = 16,
    parameter int SW = 20
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sum;
    logic [DW-1:0] out_max;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_max
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_max
    );
endinterface

// File: rtl/pipeline_result_accumulator.sv
// rtl/pipeline_result_accumulator.sv - windowed sum/max accumulator with single-entry output register
module pipeline_result_accumulator #(
    parameter int WIN = 4,
    parameter int DW  = 16,
    parameter int SW  = 20,
    parameter int CW  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    pipeline_result_accumulator_if.slave  bus,
    output logic [CW-1:0]                 win_cnt
);

    logic [SW-1:0] acc_sum;
    logic [DW-1:0] acc_max;
    logic          last_slot;
    logic          take;
    logic [SW-1:0] next_sum;
    logic [DW-1:0] next_max;

    // Only the window-finishing sample has to wait for the output register to drain.
    assign last_slot    = (win_cnt == CW'(WIN - 1));
    assign bus.in_ready = !(last_slot && bus.out_valid && !bus.out_ready);
    assign take         = bus.in_valid && bus.in_ready && !clear;

    // The first sample of a window loads the max directly so a previous window never leaks in.
    always_comb begin
        next_sum = acc_sum + SW'(bus.in_data);
        next_max = acc_max;
        if (win_cnt == '0 || bus.in_data > acc_max) begin
            next_max = bus.in_data;
        end
    end

    // Accumulation, window completion and the output handshake share one register update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_cnt       <= '0;
            acc_sum       <= '0;
            acc_max       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_max   <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (clear) begin
                win_cnt <= '0;
                acc_sum <= '0;
            end else if (take) begin
                if (last_slot) begin
                    bus.out_sum   <= next_sum;
                    bus.out_max   <= next_max;
                    bus.out_valid <= 1'b1;
                    win_cnt       <= '0;
                    acc_sum       <= '0;
                end else begin
                    acc_sum <= next_sum;
                    acc_max <= next_max;
                    win_cnt <= win_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_result_accumulator.sv
// tb/tb_pipeline_result_accumulator.sv - randomized bench with queue-based window model
module tb_pipeline_result_accumulator;
    localparam int WIN = 4;
    localparam int DW  = 16;
    localparam int SW  = 20;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic [CW-1:0] win_cnt;

    pipeline_result_accumulator_if #(.DW(DW), .SW(SW)) bus ();

    pipeline_result_accumulator #(.WIN(WIN), .DW(DW), .SW(SW), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .bus     (bus),
        .win_cnt (win_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    // Model: the current window is a queue of samples; the result is computed from the queue.
    int unsigned win_q[$];
    bit          m_valid = 1'b0;
    longint      m_sum   = 0;
    longint      m_max   = 0;

    function automatic bit model_ready();
        return !(win_q.size() == WIN - 1 && m_valid && !bus.out_ready);
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            win_q.delete();
            m_valid = 1'b0;
            m_sum   = 0;
            m_max   = 0;
        end else begin
            bit rdy;
            rdy = model_ready();
            if (m_valid && bus.out_ready) m_valid = 1'b0;
            if (clear) begin
                win_q.delete();
            end else if (bus.in_valid && rdy) begin
                win_q.push_back(int'(bus.in_data));
                if (win_q.size() == WIN) begin
                    longint s;
                    longint mx;
                    s  = 0;
                    mx = 0;
                    foreach (win_q[i]) begin
                        s += win_q[i];
                        if (win_q[i] > mx) mx = win_q[i];
                    end
                    m_valid = 1'b1;
                    m_sum   = s;
                    m_max   = mx;
                    win_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", longint'(bus.out_valid), longint'(m_valid));
            chk("win_cnt",   longint'(win_cnt),       longint'(win_q.size()));
            chk("in_ready",  longint'(bus.in_ready),  longint'(model_ready()));
            chk("out_sum",   longint'(bus.out_sum),   m_sum);
            chk("out_max",   longint'(bus.out_max),   m_max);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned v);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(v);
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int unsigned cnts[4];
        int unsigned win_a[4];
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset with random traffic on the inputs.
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = DW'($urandom_range(0, 65535));
            tick();
        end
        started = 1'b1;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_sum",   longint'(bus.out_sum), 0);
        chk("rst_out_max",   longint'(bus.out_max), 0);
        chk("rst_win_cnt",   longint'(win_cnt), 0);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        chk("rst_in_ready", longint'(bus.in_ready), 1);

        // Basic window.
        win_a = '{6, 18, 27, 10};
        cnts  = '{1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            send(win_a[i]);
            chk("basic_win_cnt", longint'(win_cnt), longint'(cnts[i]));
        end
        chk("basic_valid", longint'(bus.out_valid), 1);
        chk("basic_sum",   longint'(bus.out_sum), 61);
        chk("basic_max",   longint'(bus.out_max), 27);
        idle(1);

        // Width boundary, then all-zero window.
        for (int i = 0; i < 4; i++) send(32'hFFFF);
        chk("full_sum", longint'(bus.out_sum), 20'h3FFFC);
        chk("full_max", longint'(bus.out_max), 16'hFFFF);
        for (int i = 0; i < 4; i++) send(0);
        chk("zero_sum", longint'(bus.out_sum), 0);
        chk("zero_max", longint'(bus.out_max), 0);
        idle(1);

        // Backpressure on the window-finishing sample.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(i);
        chk("bp_first_sum", longint'(bus.out_sum), 10);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(8);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_stall_ready", longint'(bus.in_ready), 0);
            chk("bp_hold_sum",    longint'(bus.out_sum), 10);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("bp_b2b_valid", longint'(bus.out_valid), 1);
        chk("bp_b2b_sum",   longint'(bus.out_sum), 26);
        chk("bp_b2b_max",   longint'(bus.out_max), 8);
        idle(1);

        // Gaps and clear, with a sample presented during clear.
        send(3);
        idle(5);
        send(9);
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(50);
        tick();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clear_win_cnt", longint'(win_cnt), 0);
        for (int i = 0; i < 4; i++) send(1);
        chk("clear_sum", longint'(bus.out_sum), 4);
        chk("clear_max", longint'(bus.out_max), 1);
        idle(1);

        // Reset mid-window, then reset with a pending result.
        send(2);
        send(2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) send(2);
        chk("rstmid_sum", longint'(bus.out_sum), 8);
        idle(1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(5);
        chk("pend_valid", longint'(bus.out_valid), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("pend_dropped", longint'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        idle(1);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 70);
            bus.in_data   = ($urandom_range(0, 9) == 0) ? DW'(16'hFFFF)
                                                        : DW'($urandom_range(0, 65535));
            bus.out_ready = ($urandom_range(0, 99) < 60);
            clear         = ($urandom_range(0, 99) < 3);
            rst           = !($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
